// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the two-requester shared-adder arbiter.
// Holds the FSM state encoding, the seven-segment table and the latency limits.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned ADD_LAT_MIN = 1;
  localparam int unsigned ADD_LAT_MAX = 15;

  // Active-low hex glyphs, entry i lives at SEG_TABLE[i] (listed F down to 0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/adder_arbiter_rca.sv
// 4-bit ripple-carry adder: a + b + cin, carry-out on cout.
module ripple_carry_4_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[4];

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one 4-bit adder; round-robin grant, ADD_LATENCY-cycle
// settle, one-cycle ack, registered sum/cout and seven-segment display of sum.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned ADD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       cin0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       cin1,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic [3:0] sum,
  output logic       cout,
  output logic [6:0] seg,
  output logic       busy
);

  // Out-of-range latencies are clamped so the 4-bit wait counter stays valid.
  localparam int unsigned LAT = (ADD_LATENCY < ADD_LAT_MIN) ? ADD_LAT_MIN :
                                (ADD_LATENCY > ADD_LAT_MAX) ? ADD_LAT_MAX : ADD_LATENCY;
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_e     state_q;
  logic [1:0] gnt_q;
  logic [1:0] ack_q;
  logic       win_q;
  logic       last_q;
  logic [3:0] cnt_q;
  logic [3:0] op_a_q;
  logic [3:0] op_b_q;
  logic       op_cin_q;
  logic [3:0] sum_q;
  logic       cout_q;
  logic [6:0] seg_q;

  logic       win_d;
  logic [3:0] op_a_d;
  logic [3:0] op_b_d;
  logic       op_cin_d;
  logic [3:0] rca_sum;
  logic       rca_cout;

  // Contention goes to whoever was not served last; a lone request wins outright.
  always_comb begin
    win_d    = (req == 2'b11) ? ~last_q : req[1];
    op_a_d   = win_d ? a1   : a0;
    op_b_d   = win_d ? b1   : b0;
    op_cin_d = win_d ? cin1 : cin0;
  end

  ripple_carry_4_bit_adder u_rca (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (op_cin_q),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_cin_q <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      seg_q    <= seg_encode(4'h0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req != 2'b00) begin
            gnt_q    <= win_d ? 2'b10 : 2'b01;
            win_q    <= win_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_cin_q <= op_cin_d;
            cnt_q    <= CNT_LOAD;
            state_q  <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            sum_q   <= rca_sum;
            cout_q  <= rca_cout;
            seg_q   <= seg_encode(rca_sum);
            ack_q   <= gnt_q;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          last_q  <= win_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          ack_q   <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign seg  = seg_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: one instance at ADD_LATENCY=1, one at 3,
// both driven by the same stimulus; hand-computed expectations.
module tb_adder_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] a0, b0, a1, b1;
  logic       cin0, cin1;

  logic [1:0] u1_gnt, u1_ack, u3_gnt, u3_ack;
  logic [3:0] u1_sum, u3_sum;
  logic       u1_cout, u3_cout, u1_busy, u3_busy;
  logic [6:0] u1_seg, u3_seg;

  int errors = 0;
  int checks = 0;

  adder_arbiter #(.ADD_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt(u1_gnt), .ack(u1_ack), .sum(u1_sum), .cout(u1_cout),
    .seg(u1_seg), .busy(u1_busy)
  );

  adder_arbiter #(.ADD_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt(u3_gnt), .ack(u3_ack), .sum(u3_sum), .cout(u3_cout),
    .seg(u3_seg), .busy(u3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_g;
    rst_n = 1'b0; req = 2'b00;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    step(); step();

    // Reset state
    chk("rst_gnt",  8'(u1_gnt),  8'h00);
    chk("rst_ack",  8'(u1_ack),  8'h00);
    chk("rst_sum",  8'(u1_sum),  8'h00);
    chk("rst_cout", 8'(u1_cout), 8'h00);
    chk("rst_seg",  8'(u1_seg),  8'b1000000);
    chk("rst_busy", 8'(u1_busy), 8'h00);
    chk("rst_busy3", 8'(u3_busy), 8'h00);
    rst_n = 1'b1;

    // Latency 1: 3 + 4 + 1 = 8
    req = 2'b01; a0 = 4'h3; b0 = 4'h4; cin0 = 1'b1;
    step();
    chk("a_gnt",  8'(u1_gnt),  8'h01);
    chk("a_busy", 8'(u1_busy), 8'h01);
    chk("a_ack0", 8'(u1_ack),  8'h00);
    req = 2'b00;
    step();
    chk("a_ack",  8'(u1_ack),  8'h01);
    chk("a_gnt1", 8'(u1_gnt),  8'h01);
    chk("a_sum",  8'(u1_sum),  8'h08);
    chk("a_cout", 8'(u1_cout), 8'h00);
    chk("a_seg",  8'(u1_seg),  8'b0000000);
    step();
    chk("a_idle_ack",  8'(u1_ack),  8'h00);
    chk("a_idle_gnt",  8'(u1_gnt),  8'h00);
    chk("a_idle_busy", 8'(u1_busy), 8'h00);
    chk("a_hold_sum",  8'(u1_sum),  8'h08);

    // Both requesting from reset, held for six operations: 0,1,0,1,0,1
    rst_n = 1'b0; step(); rst_n = 1'b1;
    a0 = 4'h9; b0 = 4'h6; cin0 = 1'b1;
    a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1;
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      step();
      chk("rr_gnt",   8'(u1_gnt), 8'(exp_g));
      chk("rr_noack", 8'(u1_ack), 8'h00);
      step();
      chk("rr_ack",  8'(u1_ack),  8'(exp_g));
      chk("rr_sum",  8'(u1_sum),  (k % 2 == 1) ? 8'h0F : 8'h00);
      chk("rr_cout", 8'(u1_cout), 8'h01);
      chk("rr_seg",  8'(u1_seg),  (k % 2 == 1) ? 8'b0001110 : 8'b1000000);
      step();
      chk("rr_idle_gnt",  8'(u1_gnt),  8'h00);
      chk("rr_idle_busy", 8'(u1_busy), 8'h00);
    end

    // Reset in the middle of a latency-3 ADD
    req = 2'b00; rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 2'b01; a0 = 4'h5; b0 = 4'h5; cin0 = 1'b0;
    step();
    chk("mr_gnt",  8'(u3_gnt),  8'h01);
    chk("mr_busy", 8'(u3_busy), 8'h01);
    req = 2'b00;
    step();
    chk("mr_inadd_busy", 8'(u3_busy), 8'h01);
    chk("mr_inadd_ack",  8'(u3_ack),  8'h00);
    rst_n = 1'b0;
    step();
    chk("mr_gnt0",  8'(u3_gnt),  8'h00);
    chk("mr_ack0",  8'(u3_ack),  8'h00);
    chk("mr_sum0",  8'(u3_sum),  8'h00);
    chk("mr_cout0", 8'(u3_cout), 8'h00);
    chk("mr_seg0",  8'(u3_seg),  8'b1000000);
    chk("mr_busy0", 8'(u3_busy), 8'h00);
    chk("mr_u1sum", 8'(u1_sum),  8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_noack", 8'(u3_ack),  8'h00);
      chk("mr_idle",  8'(u3_busy), 8'h00);
    end

    // Latency 3, req0 dropped and operands changed during ADD: 7 + 2 + 1 = A
    req = 2'b11; a0 = 4'h7; b0 = 4'h2; cin0 = 1'b1;
    a1 = 4'h1; b1 = 4'h1; cin1 = 1'b0;
    step();
    chk("l3_gnt",  8'(u3_gnt),  8'h01);
    chk("l3_busy", 8'(u3_busy), 8'h01);
    req = 2'b10; a0 = 4'hF; b0 = 4'hF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("l3_wait_busy", 8'(u3_busy), 8'h01);
      chk("l3_wait_ack",  8'(u3_ack),  8'h00);
      chk("l3_wait_gnt",  8'(u3_gnt),  8'h01);
    end
    step();
    chk("l3_ack",  8'(u3_ack),  8'h01);
    chk("l3_sum",  8'(u3_sum),  8'h0A);
    chk("l3_cout", 8'(u3_cout), 8'h00);
    chk("l3_seg",  8'(u3_seg),  8'b0001000);
    chk("l3_busy4", 8'(u3_busy), 8'h01);
    step();
    chk("l3_idle_ack",  8'(u3_ack),  8'h00);
    chk("l3_idle_gnt",  8'(u3_gnt),  8'h00);
    chk("l3_idle_busy", 8'(u3_busy), 8'h00);
    chk("l3_hold_sum",  8'(u3_sum),  8'h0A);
    step();
    chk("l3_next_gnt",  8'(u3_gnt),  8'h02);
    chk("l3_next_busy", 8'(u3_busy), 8'h01);
    req = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
